// File: rtl/sqmod_seq.sv
// sqmod_seq: sequenced (B*B) mod A.
// Squares B by shift-add over BW cycles, then reduces the PW-bit product
// by restoring shift-subtract over PW cycles, MSB first.
// Ports:
//   clk    - system clock, rising edge
//   reset  - asynchronous active-high reset
//   start  - request, sampled only while idle
//   a_in   - modulus A (AW bits), captured on accepted start
//   b_in   - operand B (BW bits), captured on accepted start
//   busy   - operation in progress (SQUARE/REDUCE)
//   done   - one-cycle pulse, y/err valid
//   y      - result, held until next done
//   err    - A==0 flag for last operation, held with y
//
// state    | meaning
// S_IDLE   | waiting for start
// S_SQUARE | shift-add squaring, one bit of B per cycle
// S_REDUCE | restoring reduction, one product bit per cycle
// S_DONE   | single-cycle done pulse, y/err already updated
module sqmod_seq #(
  parameter int AW = 8,
  parameter int BW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] a_in,
  input  logic [BW-1:0] b_in,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] y,
  output logic          err
);

  localparam int PW = 2 * BW;
  localparam int CW = (PW > 1) ? $clog2(PW) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SQUARE,
    S_REDUCE,
    S_DONE
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_a, w_a_nxt;
  logic [BW-1:0] r_b, w_b_nxt;
  logic [PW-1:0] r_acc, w_acc_nxt;
  logic [AW:0]   r_rem, w_rem_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [AW-1:0] r_y, w_y_nxt;
  logic          r_err, w_err_nxt;

  logic [PW-1:0] w_addend;
  logic [AW:0]   w_shift;
  logic [AW:0]   w_rem_red;

  // Partial product for the current bit of B.
  assign w_addend = PW'(r_b) << r_cnt;

  // rem < A < 2^AW, so the top bit of rem is always zero before shifting.
  assign w_shift   = {r_rem[AW-1:0], r_acc[PW-1]};
  assign w_rem_red = (w_shift >= {1'b0, r_a}) ? (w_shift - {1'b0, r_a}) : w_shift;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_y     <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_acc   <= w_acc_nxt;
      r_rem   <= w_rem_nxt;
      r_cnt   <= w_cnt_nxt;
      r_y     <= w_y_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_acc_nxt   = r_acc;
    w_rem_nxt   = r_rem;
    w_cnt_nxt   = r_cnt;
    w_y_nxt     = r_y;
    w_err_nxt   = r_err;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_a_nxt     = a_in;
          w_b_nxt     = b_in;
          w_acc_nxt   = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_SQUARE;
        end
      end
      S_SQUARE: begin
        if (r_b[r_cnt[CW-1:0] % BW]) w_acc_nxt = r_acc + w_addend;
        w_cnt_nxt = r_cnt + CW'(1);
        if (r_cnt == CW'(BW - 1)) begin
          if (r_a == '0) begin
            // y/err update on the edge entering DONE so they align with done.
            w_y_nxt     = '0;
            w_err_nxt   = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_rem_nxt   = '0;
            w_cnt_nxt   = '0;
            w_state_nxt = S_REDUCE;
          end
        end
      end
      S_REDUCE: begin
        w_rem_nxt = w_rem_red;
        w_acc_nxt = r_acc << 1;
        w_cnt_nxt = r_cnt + CW'(1);
        if (r_cnt == CW'(PW - 1)) begin
          w_y_nxt     = w_rem_red[AW-1:0];
          w_err_nxt   = 1'b0;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign busy = (r_state == S_SQUARE) || (r_state == S_REDUCE);
  assign done = (r_state == S_DONE);
  assign y    = r_y;
  assign err  = r_err;

endmodule

// File: tb/tb_sqmod_seq.sv
// Directed bench for sqmod_seq with hand-computed (B*B) mod A results.
module tb_sqmod_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] a_in;
  logic [3:0] b_in;
  logic       busy;
  logic       done;
  logic [7:0] y;
  logic       err;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] last_y = '0;

  sqmod_seq #(.AW(8), .BW(4)) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .a_in (a_in),
    .b_in (b_in),
    .busy (busy),
    .done (done),
    .y    (y),
    .err  (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one op, then watch negedges: cycle c=1 is the first cycle after the
  // accepting edge. Latency is the cycle index where done is seen.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [3:0] b,
                        input logic [7:0] ey, input logic eerr, input int elat);
    int lat;
    int nbusy;
    lat   = 0;
    nbusy = 0;
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_yhold"}, y, last_y);
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) @(negedge clk);
      if (done) begin
        lat = c;
        break;
      end
      if (busy) nbusy++;
    end
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_busycnt"}, nbusy, elat - 1);
    chk({tag, "_y"}, y, ey);
    chk({tag, "_err"}, err, eerr);
    chk({tag, "_busy_at_done"}, busy, 0);
    @(negedge clk);
    chk({tag, "_done_drop"}, done, 0);
    last_y = ey;
  endtask

  initial begin
    int ndone;
    int d1;
    int d2;
    reset = 1'b1;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_y", y, 0);
    chk("rst_err", err, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    // basic results and latency
    run_op("a7b15",   8'd7,   4'd15, 8'd1,   1'b0, 13);
    run_op("a10b13",  8'd10,  4'd13, 8'd9,   1'b0, 13);
    run_op("a200b15", 8'd200, 4'd15, 8'd25,  1'b0, 13);
    run_op("a255b15", 8'd255, 4'd15, 8'd225, 1'b0, 13);
    // A==0 error path, then recovery
    run_op("a0b9",    8'd0,   4'd9,  8'd0,   1'b1, 5);
    run_op("a5b3",    8'd5,   4'd3,  8'd4,   1'b0, 13);
    // edge operands
    run_op("a5b0",    8'd5,   4'd0,  8'd0,   1'b0, 13);
    run_op("a1b15",   8'd1,   4'd15, 8'd0,   1'b0, 13);
    run_op("a3b1",    8'd3,   4'd1,  8'd1,   1'b0, 13);

    // start pulses and operand changes mid-op, then start held high:
    // first op 7*7 mod 11 = 5; second op takes a_in/b_in present in the
    // IDLE cycle after DONE: 5*5 mod 9 = 7.
    ndone = 0;
    d1 = 0;
    d2 = 0;
    @(negedge clk);
    a_in  = 8'd11;
    b_in  = 4'd7;
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          d1 = c;
          chk("mid_y1", y, 8'd5);
        end else begin
          d2 = c;
          chk("held_y2", y, 8'd7);
        end
      end
      if (c == 14) chk("held_idle_busy", busy, 0);
      if (c == 15) chk("held_accept_busy", busy, 1);
      case (c)
        1:  start = 1'b0;
        3:  begin start = 1'b1; a_in = 8'd3; b_in = 4'd2; end
        4:  start = 1'b0;
        8:  begin start = 1'b1; a_in = 8'd9; b_in = 4'd5; end
        15: start = 1'b0;
        20: begin a_in = 8'd1; b_in = 4'd0; end
        default: ;
      endcase
    end
    chk("mid_ndone", ndone, 2);
    chk("mid_d1", d1, 13);
    chk("held_d2", d2, 27);
    last_y = 8'd7;

    // reset in the middle of an op
    @(negedge clk);
    a_in  = 8'd7;
    b_in  = 4'd15;
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    chk("pre_rst_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_y", y, 0);
    chk("mrst_err", err, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("mrst_nodone", ndone, 0);
    last_y = '0;
    run_op("post_rst", 8'd200, 4'd15, 8'd25, 1'b0, 13);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sqmod_seq.md
Name: sqmod_seq

Overview:
Multi-cycle sequenced unit that computes Y = (B*B) mod A. It squares B by iterative shift-add, then reduces the product by restoring shift-subtract. It sits beside the combinational square-modulus datapath as a low-area alternative. A start/busy/done handshake drives it from the multi-cycle controller.

Parameters:
AW, 8, width of modulus operand A and of result Y
BW, 4, width of operand B; product width PW = 2*BW

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only when busy=0
a_in  input  AW  modulus A, captured on accepted start
b_in  input  BW  operand B, captured on accepted start
busy  output  1  high from the cycle after accepted start until done
done  output  1  one-cycle pulse; y and err valid
y  output  AW  result, held until next done
err  output  1  A==0 flag for the last operation, held with y

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, y=0, err=0; all internal registers cleared. Reset mid-operation aborts it with no done pulse.
- States:
  - IDLE: start=1 latches a_in and b_in, clears acc (PW bits) and cnt, goes to SQUARE, busy=1.
  - SQUARE: BW cycles. Iteration i: if b[i] then acc += b << i. After iteration BW-1: if A==0 go to DONE with err=1 and y=0; else load rem=0 and cnt=0, go to REDUCE.
  - REDUCE: PW cycles, MSB of acc first. rem = {rem, acc_bit}; if rem >= A then rem -= A. rem is AW+1 bits wide so there is no overflow. After PW iterations go to DONE.
  - DONE: one cycle. done=1, busy=0, y=rem[AW-1:0] (0 on err). Next state is IDLE.
- Latency (accepted start edge to done-high cycle): BW+PW+1 cycles (13 at defaults). A==0 case: BW+1 cycles (5).
- start while busy=1 or in DONE: ignored, not queued. start held high continuously is accepted again in the first IDLE cycle after DONE, so the back-to-back period is BW+PW+2 cycles.
- a_in and b_in changes after acceptance have no effect.
- Arithmetic is unsigned throughout. The product is exact in PW bits, since (2^BW-1)^2 < 2^PW.
- Remainder is always < A, so it fits in AW bits.
- A==1 yields y=0 with err=0.
- y and err change only in the DONE cycle and hold otherwise. The done pulse and the y update occur in the same cycle.

Test Plan:
1. Reset, then start with A=7, B=15 -> done exactly 13 cycles later, y=1, err=0; busy high for the 12 cycles before done.
2. A=10, B=13 -> y=9. Then A=200, B=15 -> y=25. Then A=255, B=15 -> y=225, which verifies the no-reduction path.
3. A=0, B=9 -> done after 5 cycles, y=0, err=1. Next op A=5, B=3 -> y=4, err=0.
4. Edge operands: B=0, A=5 -> y=0. A=1, B=15 -> y=0, err=0. A=3, B=1 -> y=1.
5. Pulse start again at cycles 3 and 8 of an active op, and change a_in/b_in during it -> result unaffected, single done pulse. start held high -> next op accepted the cycle after DONE.
6. Assert reset at cycle 6 of an op -> busy, done, y and err go to 0 immediately, no done pulse. A new start after reset release completes normally with correct y.
